// File: rtl/matrix_mult.sv
// Serial-in / serial-out unsigned matrix multiplier C = A x B (A is m x n, B is n x m).
// Operands are streamed in row-major order, C is streamed out with done. One MAC per cycle.
module matrix_mult #(
    parameter int DW = 8,
    parameter int m  = 8,
    parameter int n  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          done
);

    localparam int MN  = m * n;
    localparam int MM  = m * m;
    localparam int TOT = 2 * MN;
    localparam int AW  = (MN > 1) ? $clog2(MN) : 1;
    localparam int CW  = (MM > 1) ? $clog2(MM) : 1;
    localparam int LW  = $clog2(TOT);
    localparam int KW  = (n > 1) ? $clog2(n) : 1;
    localparam int JW  = (m > 1) ? $clog2(m) : 1;
    localparam int ACW = 2 * DW + $clog2(n) + 1;

    localparam logic [LW-1:0] L_LAST = LW'(TOT - 1);
    localparam logic [LW-1:0] L_MN   = LW'(MN);
    localparam logic [KW-1:0] K_LAST = KW'(n - 1);
    localparam logic [JW-1:0] J_LAST = JW'(m - 1);
    localparam logic [CW-1:0] C_LAST = CW'(MM - 1);
    localparam logic [AW-1:0] A_STEP = AW'(m);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        OUTPUT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [LW-1:0]      r_lcnt;
    logic [DW-1:0]      r_a [MN];
    logic [DW-1:0]      r_b [MN];
    logic [DW-1:0]      r_c [MM];
    logic [KW-1:0]      r_k;
    logic [JW-1:0]      r_j;
    logic [AW-1:0]      r_a_ptr;
    logic [AW-1:0]      r_a_base;
    logic [AW-1:0]      r_b_ptr;
    logic [CW-1:0]      r_c_ptr;
    logic [CW-1:0]      r_ocnt;
    logic [ACW-1:0]     r_acc;
    logic [DW-1:0]      r_data_out;
    logic               r_done;

    logic               w_load_last;
    logic               w_is_a;
    logic [AW-1:0]      w_a_widx;
    logic [AW-1:0]      w_b_widx;
    logic               w_k_last;
    logic               w_j_last;
    logic               w_calc_last;
    logic               w_out_last;
    logic [CW-1:0]      w_ocnt_nxt;
    logic [2*DW-1:0]    w_prod;
    logic [ACW-1:0]     w_sum;

    assign w_load_last = (r_lcnt == L_LAST);
    assign w_is_a      = (r_lcnt < L_MN);
    assign w_a_widx    = AW'(r_lcnt);
    assign w_b_widx    = AW'(r_lcnt - L_MN);
    assign w_k_last    = (r_k == K_LAST);
    assign w_j_last    = (r_j == J_LAST);
    assign w_calc_last = w_k_last && (r_c_ptr == C_LAST);
    assign w_out_last  = (r_ocnt == C_LAST);
    assign w_ocnt_nxt  = r_ocnt + CW'(1);
    assign w_prod      = r_a[r_a_ptr] * r_b[r_b_ptr];
    assign w_sum       = r_acc + ACW'(w_prod);

    assign data_out = r_data_out;
    assign done     = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)       w_next = LOAD;
            LOAD:    if (w_load_last) w_next = CALC;
            CALC:    if (w_calc_last) w_next = OUTPUT;
            OUTPUT:  if (w_out_last)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lcnt     <= '0;
            r_k        <= '0;
            r_j        <= '0;
            r_a_ptr    <= '0;
            r_a_base   <= '0;
            r_b_ptr    <= '0;
            r_c_ptr    <= '0;
            r_ocnt     <= '0;
            r_acc      <= '0;
            r_data_out <= '0;
            r_done     <= 1'b0;
            for (int unsigned i = 0; i < MN; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
            for (int unsigned i = 0; i < MM; i++) begin
                r_c[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_data_out <= '0;
                    r_done     <= 1'b0;
                    r_lcnt     <= '0;
                end
                LOAD: begin
                    if (w_is_a) begin
                        r_a[w_a_widx] <= data_in;
                    end else begin
                        r_b[w_b_widx] <= data_in;
                    end
                    r_lcnt <= w_load_last ? '0 : r_lcnt + LW'(1);
                end
                CALC: begin
                    if (w_k_last) begin
                        r_c[r_c_ptr] <= w_sum[DW-1:0];
                        r_acc        <= '0;
                        r_k          <= '0;
                        if (w_calc_last) begin
                            // C[0][0] is presented on the same edge the final MAC lands; when the
                            // result is a single element that MAC is C[0][0] itself, so bypass the array.
                            r_data_out <= (MM == 1) ? w_sum[DW-1:0] : r_c[0];
                            r_done     <= 1'b1;
                            r_ocnt     <= '0;
                            r_j        <= '0;
                            r_a_ptr    <= '0;
                            r_a_base   <= '0;
                            r_b_ptr    <= '0;
                            r_c_ptr    <= '0;
                        end else begin
                            r_c_ptr <= r_c_ptr + CW'(1);
                            if (w_j_last) begin
                                r_j      <= '0;
                                r_a_ptr  <= r_a_ptr + AW'(1);
                                r_a_base <= r_a_ptr + AW'(1);
                                r_b_ptr  <= '0;
                            end else begin
                                r_j     <= r_j + JW'(1);
                                r_a_ptr <= r_a_base;
                                r_b_ptr <= AW'(r_j) + AW'(1);
                            end
                        end
                    end else begin
                        r_acc   <= w_sum;
                        r_k     <= r_k + KW'(1);
                        r_a_ptr <= r_a_ptr + AW'(1);
                        r_b_ptr <= r_b_ptr + A_STEP;
                    end
                end
                OUTPUT: begin
                    if (w_out_last) begin
                        r_data_out <= '0;
                        r_done     <= 1'b0;
                        r_ocnt     <= '0;
                    end else begin
                        r_data_out <= r_c[w_ocnt_nxt];
                        r_ocnt     <= w_ocnt_nxt;
                    end
                end
                default: begin
                    r_data_out <= '0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mult.sv
// Bench for matrix_mult: three instances (2x2 inner 2, 2x2 inner 3, 1x1 inner 1) checked
// against a plain-arithmetic product model plus hand-computed literal results.
module tb_matrix_mult;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rs [3];
    logic       st [3];
    logic       dn [3];
    logic [7:0] di [3];
    logic [7:0] dq [3];

    matrix_mult #(.DW(8), .m(2), .n(2)) u_dut0 (
        .clk(clk), .reset(rs[0]), .start(st[0]), .data_in(di[0]), .data_out(dq[0]), .done(dn[0]));
    matrix_mult #(.DW(8), .m(2), .n(3)) u_dut1 (
        .clk(clk), .reset(rs[1]), .start(st[1]), .data_in(di[1]), .data_out(dq[1]), .done(dn[1]));
    matrix_mult #(.DW(8), .m(1), .n(1)) u_dut2 (
        .clk(clk), .reset(rs[2]), .start(st[2]), .data_in(di[2]), .data_out(dq[2]), .done(dn[2]));

    int checks = 0;
    int errors = 0;
    int dims_m [3] = '{2, 2, 1};
    int dims_n [3] = '{2, 3, 1};
    int exp_vals [3][128];
    int exp_wr [3] = '{0, 0, 0};
    int exp_rd [3] = '{0, 0, 0};
    int ops [$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference product from the operand list: A row-major m x n, then B row-major n x m.
    task automatic model_push(input int id);
        int mm, nn, s;
        mm = dims_m[id];
        nn = dims_n[id];
        for (int i = 0; i < mm; i++) begin
            for (int j = 0; j < mm; j++) begin
                s = 0;
                for (int k = 0; k < nn; k++) begin
                    s += ops[i*nn + k] * ops[mm*nn + k*mm + j];
                end
                exp_vals[id][exp_wr[id]] = s % 256;
                exp_wr[id]++;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int id = 0; id < 3; id++) begin
            if (dn[id] === 1'b1) begin
                if (exp_rd[id] < exp_wr[id]) begin
                    chk($sformatf("dut%0d_c%0d", id, exp_rd[id]), int'(dq[id]), exp_vals[id][exp_rd[id]]);
                    exp_rd[id]++;
                end else begin
                    chk($sformatf("dut%0d_unexpected_done", id), 1, 0);
                end
            end
        end
    end

    task automatic run(input int id, input bit hold, input bit pulse);
        int mm, nn, tot, cyc, hi;
        mm  = dims_m[id];
        nn  = dims_n[id];
        tot = 2 * mm * nn;
        model_push(id);
        st[id] = 1'b1;
        di[id] = 8'd0;
        @(negedge clk);
        st[id] = hold;
        for (int i = 0; i < tot; i++) begin
            di[id] = 8'(ops[i]);
            @(negedge clk);
        end
        di[id] = 8'd0;
        cyc = 0;
        while (dn[id] !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("dut%0d_latency", id), cyc, mm * mm * nn);
        hi = 0;
        while (dn[id] === 1'b1 && hi < 300) begin
            st[id] = pulse;
            @(negedge clk);
            hi++;
        end
        st[id] = 1'b0;
        chk($sformatf("dut%0d_done_len", id), hi, mm * mm);
        chk($sformatf("dut%0d_consumed", id), exp_rd[id], exp_wr[id]);
        exp_rd[id] = exp_wr[id];
    endtask

    task automatic abort_run(input int id, input int n_load, input int calc_wait);
        st[id] = 1'b1;
        @(negedge clk);
        st[id] = 1'b0;
        for (int i = 0; i < n_load; i++) begin
            di[id] = 8'(ops[i]);
            @(negedge clk);
        end
        repeat (calc_wait) @(negedge clk);
        rs[id] = 1'b1;
        @(negedge clk);
        rs[id] = 1'b0;
        chk("abort_done", int'(dn[id]), 0);
        chk("abort_dout", int'(dq[id]), 0);
        di[id] = 8'd0;
        repeat (3) @(negedge clk);
        chk("abort_idle_done", int'(dn[id]), 0);
    endtask

    task automatic pin(input int id, input int base, input int l0, input int l1, input int l2, input int l3);
        int lit [4];
        lit = '{l0, l1, l2, l3};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("model%0d_%0d", id, i), exp_vals[id][base + i], lit[i]);
        end
    endtask

    initial begin
        int base;
        for (int id = 0; id < 3; id++) begin
            rs[id] = 1'b1;
            st[id] = 1'b0;
            di[id] = 8'd0;
        end
        repeat (3) @(negedge clk);
        for (int id = 0; id < 3; id++) begin
            chk($sformatf("reset_done%0d", id), int'(dn[id]), 0);
            chk($sformatf("reset_dout%0d", id), int'(dq[id]), 0);
            rs[id] = 1'b0;
        end
        @(negedge clk);

        ops = '{1, 2, 3, 4, 5, 6, 7, 8};
        base = exp_wr[0];
        run(0, 1'b0, 1'b0);
        pin(0, base, 19, 22, 43, 50);

        ops = '{255, 255, 255, 255, 255, 255, 255, 255};
        base = exp_wr[0];
        run(0, 1'b0, 1'b0);
        pin(0, base, 2, 2, 2, 2);

        ops = '{1, 2, 3, 4, 5, 6, 7, 8};
        abort_run(0, 3, 0);
        abort_run(0, 8, 3);
        base = exp_wr[0];
        run(0, 1'b0, 1'b0);
        pin(0, base, 19, 22, 43, 50);

        base = exp_wr[0];
        run(0, 1'b1, 1'b1);
        pin(0, base, 19, 22, 43, 50);
        repeat (2) @(negedge clk);

        ops = '{1, 2, 3, 4, 5, 6, 1, 2, 3, 4, 5, 6};
        base = exp_wr[1];
        run(1, 1'b0, 1'b0);
        pin(1, base, 22, 28, 49, 64);

        ops = '{1, 2, 3, 4, 5, 6, 7, 8};
        run(0, 1'b0, 1'b0);
        ops = '{2, 0, 1, 3, 4, 5, 6, 7};
        base = exp_wr[0];
        run(0, 1'b0, 1'b0);
        pin(0, base, 8, 10, 22, 26);

        ops = '{7, 9};
        base = exp_wr[2];
        run(2, 1'b0, 1'b0);
        chk("model2_a", exp_vals[2][base], 63);
        ops = '{200, 200};
        base = exp_wr[2];
        run(2, 1'b0, 1'b0);
        chk("model2_b", exp_vals[2][base], 64);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
